// File: rtl/ddr3_seq_pkg.sv
// ddr3_seq_pkg: shared states, ACK timeout and direction encoding for the DDR3 sequencer
package ddr3_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HALF,
        S_GO,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT
    } state_t;
    localparam int ACK_TIMEOUT = 16;
    localparam int TO_W = $clog2(ACK_TIMEOUT);
    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;
    function automatic logic [1:0] half_mask(input logic h);
        return h ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/wb_ddr3_seq_if.sv
// wb_ddr3_seq_if: request, ping-pong handshake and DDR3 UI signals of the sequencer
interface wb_ddr3_seq_if #(
    parameter int BUF_DEPTH      = 10,
    parameter int MEM_ADDR_DEPTH = 28,
    parameter int LEN_WIDTH      = 24
);
    logic                      i_app_phy_init_done;
    logic                      i_req_stb;
    logic                      o_req_rdy;
    logic                      i_req_dir;
    logic [MEM_ADDR_DEPTH-1:0] i_req_addr;
    logic [LEN_WIDTH-1:0]      i_req_len;
    logic [1:0]                i_half_ok;
    logic [1:0]                o_half_done;
    logic                      o_busy;
    logic                      o_done;
    logic                      o_fault;
    logic                      o_ibuf_go;
    logic                      i_ibuf_bsy;
    logic                      i_ibuf_ddr3_fault;
    logic [BUF_DEPTH-1:0]      o_ibuf_count;
    logic [BUF_DEPTH-1:0]      o_ibuf_start_addrb;
    logic [MEM_ADDR_DEPTH-1:0] o_ibuf_ddr3_addrb;
    logic                      o_obuf_go;
    logic                      i_obuf_bsy;
    logic                      i_obuf_ddr3_fault;
    logic [BUF_DEPTH-1:0]      o_obuf_count;
    logic [BUF_DEPTH-1:0]      o_obuf_start_addra;
    logic [MEM_ADDR_DEPTH-1:0] o_obuf_ddr3_addra;

    modport master (
        output i_app_phy_init_done, i_req_stb, i_req_dir, i_req_addr, i_req_len, i_half_ok,
               i_ibuf_bsy, i_ibuf_ddr3_fault, i_obuf_bsy, i_obuf_ddr3_fault,
        input  o_req_rdy, o_half_done, o_busy, o_done, o_fault,
               o_ibuf_go, o_ibuf_count, o_ibuf_start_addrb, o_ibuf_ddr3_addrb,
               o_obuf_go, o_obuf_count, o_obuf_start_addra, o_obuf_ddr3_addra
    );

    modport slave (
        input  i_app_phy_init_done, i_req_stb, i_req_dir, i_req_addr, i_req_len, i_half_ok,
               i_ibuf_bsy, i_ibuf_ddr3_fault, i_obuf_bsy, i_obuf_ddr3_fault,
        output o_req_rdy, o_half_done, o_busy, o_done, o_fault,
               o_ibuf_go, o_ibuf_count, o_ibuf_start_addrb, o_ibuf_ddr3_addrb,
               o_obuf_go, o_obuf_count, o_obuf_start_addra, o_obuf_ddr3_addra
    );
endinterface

// File: rtl/wb_ddr3_seq.sv
// wb_ddr3_seq: splits a buffer<->DDR3 request into half-buffer chunks over a ping-pong buffer
module wb_ddr3_seq #(
    parameter int BUF_DEPTH      = 10,
    parameter int MEM_ADDR_DEPTH = 28,
    parameter int LEN_WIDTH      = 24
) (
    input logic          ui_clk,
    input logic          rst,
    wb_ddr3_seq_if.slave bus
);
    import ddr3_seq_pkg::*;

    localparam logic [BUF_DEPTH-1:0] HALF_B = BUF_DEPTH'(1) << (BUF_DEPTH - 1);
    localparam logic [LEN_WIDTH-1:0] HALF_L = LEN_WIDTH'(HALF_B);

    state_t                    state;
    logic                      dir;
    logic                      h;
    logic [1:0]                hr;
    logic [1:0]                hr_clr;
    logic [LEN_WIDTH-1:0]      rem;
    logic [MEM_ADDR_DEPTH-1:0] cur_addr;
    logic [MEM_ADDR_DEPTH-1:0] ddr_addr;
    logic [BUF_DEPTH-1:0]      chunk;
    logic [BUF_DEPTH-1:0]      start;
    logic [TO_W-1:0]           to;
    logic                      fault;
    logic                      done;
    logic                      ibuf_go;
    logic                      obuf_go;
    logic [1:0]                half_done;
    logic                      req;
    logic                      bad;
    logic                      bsy;
    logic                      ui_fault;
    logic                      last;

    assign req      = bus.i_req_stb && bus.i_app_phy_init_done;
    assign bad      = bus.i_req_len[0] || (bus.i_req_len == '0);
    assign bsy      = (dir == DIR_RD) ? bus.i_obuf_bsy : bus.i_ibuf_bsy;
    assign ui_fault = (dir == DIR_RD) ? bus.i_obuf_ddr3_fault : bus.i_ibuf_ddr3_fault;
    assign hr_clr   = (state == S_NEXT) ? half_mask(h) : 2'b00;
    assign last     = rem == LEN_WIDTH'(chunk);

    // Half-ready tracker: seeded on accept, then a half_ok pulse beats the NEXT clear
    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst)
            hr <= '0;
        else if (state == S_IDLE)
            hr <= (req && !bad) ? (bus.i_req_dir ? 2'b11 : 2'b00) : hr;
        else
            hr <= (hr & ~hr_clr) | bus.i_half_ok;
    end

    // Sequencer FSM with registered go/done/half_done/fault and held UI command fields
    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dir       <= DIR_WR;
            h         <= 1'b0;
            rem       <= '0;
            cur_addr  <= '0;
            ddr_addr  <= '0;
            chunk     <= '0;
            start     <= '0;
            to        <= '0;
            fault     <= 1'b0;
            done      <= 1'b0;
            ibuf_go   <= 1'b0;
            obuf_go   <= 1'b0;
            half_done <= 2'b00;
        end else begin
            done      <= 1'b0;
            half_done <= 2'b00;
            ibuf_go   <= 1'b0;
            obuf_go   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req && bad) begin
                        fault <= 1'b1;
                        done  <= 1'b1;
                    end else if (req) begin
                        dir      <= bus.i_req_dir;
                        cur_addr <= bus.i_req_addr;
                        rem      <= bus.i_req_len;
                        fault    <= 1'b0;
                        h        <= 1'b0;
                        state    <= S_WAIT_HALF;
                    end
                end
                S_WAIT_HALF: begin
                    if (hr[h]) begin
                        chunk    <= (rem < HALF_L) ? BUF_DEPTH'(rem) : HALF_B;
                        start    <= h ? HALF_B : '0;
                        ddr_addr <= cur_addr;
                        ibuf_go  <= dir == DIR_WR;
                        obuf_go  <= dir == DIR_RD;
                        state    <= S_GO;
                    end
                end
                S_GO: begin
                    to    <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bsy)
                        state <= S_WAIT_DONE;
                    else if (to == TO_W'(ACK_TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else
                        to <= to + 1'b1;
                end
                S_WAIT_DONE: begin
                    if (!bsy && ui_fault) begin
                        fault <= 1'b1;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (!bsy)
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    half_done <= half_mask(h);
                    rem       <= rem - LEN_WIDTH'(chunk);
                    cur_addr  <= cur_addr + MEM_ADDR_DEPTH'(chunk >> 1);
                    h         <= ~h;
                    done      <= last;
                    state     <= last ? S_IDLE : S_WAIT_HALF;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_req_rdy          = state == S_IDLE;
    assign bus.o_busy             = state != S_IDLE;
    assign bus.o_done             = done;
    assign bus.o_fault            = fault;
    assign bus.o_half_done        = half_done;
    assign bus.o_ibuf_go          = ibuf_go;
    assign bus.o_obuf_go          = obuf_go;
    assign bus.o_ibuf_count       = chunk;
    assign bus.o_obuf_count       = chunk;
    assign bus.o_ibuf_start_addrb = start;
    assign bus.o_obuf_start_addra = start;
    assign bus.o_ibuf_ddr3_addrb  = ddr_addr;
    assign bus.o_obuf_ddr3_addra  = ddr_addr;
endmodule

// File: doc/wb_ddr3_seq.md
WB_DDR3_SEQ -- requirements
Module: wb_ddr3_seq

Interface
REQ-001 SHALL have parameters: BUF_DEPTH, default 10, buffer address width; MEM_ADDR_DEPTH, default 28, DDR3 address width; LEN_WIDTH, default 24, request length width.
REQ-002 SHALL have port `ui_clk`, input, 1 bit: the single clock; every flop is rising-edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port `i_app_phy_init_done`, input, 1 bit: DDR3 calibration complete.
REQ-005 SHALL have port `i_req_stb`, input, 1 bit: transfer request strobe.
REQ-006 SHALL have port `o_req_rdy`, output, 1 bit: sequencer idle, request accepted.
REQ-007 SHALL have port `i_req_dir`, input, 1 bit: 0 = buffer to DDR3 (write), 1 = DDR3 to buffer (read).
REQ-008 SHALL have port `i_req_addr`, input, MEM_ADDR_DEPTH bits: DDR3 start address.
REQ-009 SHALL have port `i_req_len`, input, LEN_WIDTH bits: total length in UI count units; must be even and nonzero.
REQ-010 SHALL have port `i_half_ok`, input, 2 bits: one-cycle pulse per half; write = half filled, read = half drained.
REQ-011 SHALL have port `o_half_done`, output, 2 bits: one-cycle pulse when the chunk for that half completes.
REQ-012 SHALL have port `o_busy`, output, 1 bit: request in progress.
REQ-013 SHALL have port `o_done`, output, 1 bit: one-cycle pulse at request end.
REQ-014 SHALL have port `o_fault`, output, 1 bit: sticky error flag; cleared on the next accept.
REQ-015 SHALL have the write-side UI ports:
- `o_ibuf_go`, output, 1 bit;
- `i_ibuf_bsy`, input, 1 bit;
- `i_ibuf_ddr3_fault`, input, 1 bit;
- `o_ibuf_count`, output, BUF_DEPTH bits;
- `o_ibuf_start_addrb`, output, BUF_DEPTH bits;
- `o_ibuf_ddr3_addrb`, output, MEM_ADDR_DEPTH bits.
REQ-016 SHALL have the read-side UI ports:
- `o_obuf_go`, output, 1 bit;
- `i_obuf_bsy`, input, 1 bit;
- `i_obuf_ddr3_fault`, input, 1 bit;
- `o_obuf_count`, output, BUF_DEPTH bits;
- `o_obuf_start_addra`, output, BUF_DEPTH bits;
- `o_obuf_ddr3_addra`, output, MEM_ADDR_DEPTH bits.

Function
REQ-017 SHALL define HALF = 2^(BUF_DEPTH-1); the buffer is a ping-pong of half 0 (base 0) and half 1 (base HALF), and halves are used strictly in order 0,1,0,1 starting at 0 for every request.
REQ-018 SHALL implement FSM states IDLE, WAIT_HALF, GO, WAIT_ACK, WAIT_DONE, NEXT.
REQ-019 In IDLE, o_req_rdy SHALL be 1; i_req_stb with i_app_phy_init_done=1 accepts on that edge:
- latch dir, addr and remaining = len;
- clear o_fault;
- set half-ready bits to 00 for write, 11 for read;
- go to WAIT_HALF.
REQ-020 A request with odd or zero length SHALL NOT start a transfer: it sets o_fault, pulses o_done the next cycle and stays in IDLE.
REQ-021 While i_app_phy_init_done=0, i_req_stb SHALL be ignored.
REQ-022 An i_half_ok pulse SHALL set the matching half-ready bit in any state except IDLE; a pulse in the same cycle as that bit is cleared has set priority.
REQ-023 In WAIT_HALF, when the current half's ready bit is set, the FSM SHALL load chunk = min(remaining, HALF), count = chunk, start address = current half base, DDR3 address = current address, and go to GO.
REQ-024 GO SHALL drive o_ibuf_go (write) or o_obuf_go (read) high for exactly one cycle, then enter WAIT_ACK; the other go is never asserted.
REQ-025 In WAIT_ACK, bsy=1 SHALL move the FSM to WAIT_DONE; if bsy is not seen within 16 cycles, the FSM SHALL set o_fault, pulse o_done and return to IDLE.
REQ-026 In WAIT_DONE, the FSM SHALL wait for bsy=0; if the direction's fault input is 1 in the cycle bsy falls, it SHALL set o_fault, pulse o_done and return to IDLE without a half_done pulse.
REQ-027 NEXT SHALL perform, in one cycle:
- clear the current half-ready bit;
- pulse o_half_done for the current half;
- remaining -= chunk;
- DDR3 address += chunk/2 (two count units per DDR3 address), wrapping modulo 2^MEM_ADDR_DEPTH;
- toggle the half.
The FSM then goes to IDLE with an o_done pulse if remaining == 0, else to WAIT_HALF.
REQ-028 count, start-address and DDR3-address outputs SHALL be held stable from GO until the FSM leaves WAIT_DONE.
REQ-029 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-030 rst=1 SHALL immediately force the following, including mid-transfer:
- state IDLE;
- all go outputs, o_done, o_half_done, o_fault, o_busy = 0;
- counters, addresses and half-ready bits = 0;
- o_req_rdy = 1.
REQ-031 A transfer aborted by reset SHALL NOT produce o_done after reset releases.

Structure
REQ-032 State encodings, the ACK timeout constant (16) and the direction encoding SHALL live in a shared package, ddr3_seq_pkg.
REQ-033 The design SHALL be a single module with no sub-modules; the half-ready tracker SHALL be inline.

Verification
REQ-034 Write test: addr 0x100, len 2048, BUF_DEPTH 10, i_half_ok 01 then 10 → four go pulses:
- counts 512;
- start addresses 0/512/0/512;
- DDR3 addresses 0x100/0x200/0x300/0x400;
- o_done once.
REQ-035 Read test: len 300 → one o_obuf_go with count 300, start address 0; o_half_done = 01; o_done.
REQ-036 Fault test: i_ibuf_ddr3_fault = 1 at bsy fall on the second chunk → o_fault = 1, o_done, no further go, no o_half_done for half 1.
REQ-037 Timeout and length test:
- bsy held low after go → fault at cycle 16;
- len = 5 → o_fault with no go.
REQ-038 Reset test: rst asserted while in WAIT_DONE → outputs at reset values the same cycle; a new request afterwards completes normally.
